// File: rtl/timer_mmio.sv
// Memory-mapped 8-bit down-counting timer with a prescaler, sticky expiry flag,
// one-cycle tick pulse and a level interrupt; registers at BASE_ADDR..BASE_ADDR+7.
module timer_mmio #(
  parameter logic [7:0]  BASE_ADDR  = 8'h20,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            addr,
  input  logic [data_width-1:0] din,
  input  logic                  write_en,
  output logic [data_width-1:0] dout,
  output logic                  o_tick,
  output logic                  o_irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_RELOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  state_e                state_q, state_d;
  logic                  auto_q, auto_d;
  logic                  irq_en_q, irq_en_d;
  logic                  flag_q, flag_d;
  logic                  tick_q, tick_d;
  logic [data_width-1:0] reload_q, reload_d;
  logic [data_width-1:0] count_q, count_d;
  logic [data_width-1:0] prescale_q, prescale_d;
  logic [data_width-1:0] pcnt_q, pcnt_d;
  logic [data_width-1:0] dout_q, dout_d;

  logic       sel;
  logic       wr;
  logic [2:0] off;
  logic       pre_tick;
  logic       expiry;

  always_comb begin
    sel        = (addr[7:3] == BASE_ADDR[7:3]);
    wr         = write_en && sel;
    off        = addr[2:0];
    state_d    = state_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    flag_d     = flag_q;
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    expiry     = 1'b0;
    pre_tick   = (state_q == S_RUN) && (pcnt_q == prescale_q);

    if (state_q == S_RUN) begin
      pcnt_d = pre_tick ? '0 : pcnt_q + data_width'(1);
      if (pre_tick) begin
        if (count_q != '0) begin
          count_d = count_q - data_width'(1);
        end else begin
          expiry = 1'b1;
          if (auto_q) count_d = reload_q;
          else        state_d = S_DONE;
        end
      end
    end

    // Bus writes are applied after the counting update so that they win any
    // same-cycle conflict; the expiry side effects (flag, tick) still happen.
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          auto_d   = din[1];
          irq_en_d = din[2];
          if (din[0]) begin
            state_d = S_RUN;
            count_d = reload_q;
            pcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
            count_d = count_q;
            pcnt_d  = pcnt_q;
          end
        end
        OFF_RELOAD:   reload_d = din;
        OFF_COUNT: begin
          count_d = din;
          pcnt_d  = '0;
        end
        OFF_STATUS:   if (din[0]) flag_d = 1'b0;
        OFF_PRESCALE: prescale_d = din;
        default: ;
      endcase
    end

    if (expiry) flag_d = 1'b1;
    tick_d = expiry;

    dout_d = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:     dout_d = {{(data_width-3){1'b0}}, irq_en_q, auto_q, state_q == S_RUN};
        OFF_RELOAD:   dout_d = reload_q;
        OFF_COUNT:    dout_d = count_q;
        OFF_STATUS:   dout_d = {{(data_width-1){1'b0}}, flag_q};
        OFF_PRESCALE: dout_d = prescale_q;
        default:      dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      flag_q     <= 1'b0;
      tick_q     <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      flag_q     <= flag_d;
      tick_q     <= tick_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      dout_q     <= dout_d;
    end
  end

  assign dout   = dout_q;
  assign o_tick = tick_q;
  assign o_irq  = flag_q & irq_en_q;

endmodule

// File: tb/tb_timer_mmio.sv
// Self-checking bench for timer_mmio: register-read scoreboard plus cycle-exact
// tick/irq expectations for one-shot, auto-reload and same-cycle conflicts.
module tb_timer_mmio;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] din;
  logic       write_en;
  logic [7:0] dout;
  logic       o_tick;
  logic       o_irq;

  int checks;
  int errors;
  logic [7:0] exp_q[$];
  logic [7:0] got;
  logic [7:0] exp;

  timer_mmio #(.BASE_ADDR(8'h20), .data_width(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .write_en(write_en),
    .dout(dout), .o_tick(o_tick), .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic we);
    addr = a; din = d; write_en = we;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    drive(a, d, 1'b1);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
    drive(a, 8'h00, 1'b0);
    @(negedge clk);
    v = dout;
  endtask

  task automatic test_reset;
    logic [7:0] offs [3];
    logic [7:0] vals [3];
    #1;
    checks++; if (dout !== 8'h00)  begin errors++; $display("FAIL rst_dout got=%h exp=00", dout); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", o_tick); end
    checks++; if (o_irq !== 1'b0)  begin errors++; $display("FAIL rst_irq got=%b exp=0", o_irq); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h00);
      bus_read(8'h20 + 8'(i), got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL rst_read off=%0d got=%h exp=%h", i, got, exp); end
    end
    bus_write(8'h21, 8'hA5);
    bus_write(8'h26, 8'hFF);
    bus_write(8'h41, 8'h11);
    offs = '{8'h21, 8'h26, 8'h41};
    vals = '{8'hA5, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      bus_read(offs[i], got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL map_read addr=%h got=%h exp=%h", offs[i], got, exp); end
    end
  endtask

  task automatic test_oneshot;
    logic [7:0] offs [3];
    logic [7:0] vals [3];
    bus_write(8'h21, 8'd3);
    bus_write(8'h24, 8'd0);
    bus_write(8'h20, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (o_tick !== (k == 4)) begin errors++; $display("FAIL oneshot_tick k=%0d got=%b exp=%b", k, o_tick, k == 4); end
    end
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq got=%b exp=0", o_irq); end
    offs = '{8'h20, 8'h23, 8'h22};
    vals = '{8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      bus_read(offs[i], got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL oneshot_read addr=%h got=%h exp=%h", offs[i], got, exp); end
    end
  endtask

  task automatic test_auto_irq;
    bus_write(8'h23, 8'h01);
    bus_write(8'h21, 8'd1);
    bus_write(8'h24, 8'd2);
    bus_write(8'h20, 8'h07);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++; if (o_tick !== (k % 6 == 0)) begin errors++; $display("FAIL auto_tick k=%0d got=%b exp=%b", k, o_tick, k % 6 == 0); end
      checks++; if (o_irq !== (k >= 6))      begin errors++; $display("FAIL auto_irq k=%0d got=%b exp=%b", k, o_irq, k >= 6); end
    end
    drive(8'h23, 8'h01, 1'b1);
    @(negedge clk);
    write_en = 1'b0;
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", o_irq); end
    for (int k = 32; k <= 36; k++) begin
      @(negedge clk);
      checks++; if (o_irq !== (k == 36))  begin errors++; $display("FAIL irq_rearm k=%0d got=%b exp=%b", k, o_irq, k == 36); end
      checks++; if (o_tick !== (k == 36)) begin errors++; $display("FAIL rearm_tick k=%0d got=%b exp=%b", k, o_tick, k == 36); end
    end
  endtask

  task automatic test_simultaneous;
    for (int k = 37; k <= 41; k++) begin
      @(negedge clk);
      checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL sim_gap_tick k=%0d got=%b exp=0", k, o_tick); end
    end
    drive(8'h23, 8'h01, 1'b1);
    @(negedge clk);
    write_en = 1'b0;
    checks++; if (o_tick !== 1'b1) begin errors++; $display("FAIL clr_on_expiry_tick got=%b exp=1", o_tick); end
    checks++; if (o_irq !== 1'b1)  begin errors++; $display("FAIL clr_on_expiry_irq got=%b exp=1", o_irq); end
    exp_q.push_back(8'h01);
    bus_read(8'h23, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL clr_on_expiry_flag got=%h exp=%h", got, exp); end
    @(negedge clk);
    bus_write(8'h22, 8'h10);
    exp_q.push_back(8'h10);
    bus_read(8'h22, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL count_wr_on_tick got=%h exp=%h", got, exp); end

    bus_write(8'h21, 8'd0);
    bus_write(8'h24, 8'd0);
    bus_write(8'h20, 8'h03);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (o_tick !== 1'b1) begin errors++; $display("FAIL every_cycle_tick k=%0d got=%b exp=1", k, o_tick); end
    end
    bus_write(8'h20, 8'h00);
    checks++; if (o_tick !== 1'b1) begin errors++; $display("FAIL stop_on_expiry_tick got=%b exp=1", o_tick); end
    @(negedge clk);
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL stopped_tick got=%b exp=0", o_tick); end
    exp_q.push_back(8'h00);
    bus_read(8'h20, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL stopped_ctrl got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reload_midrun;
    bus_write(8'h23, 8'h01);
    bus_write(8'h21, 8'd200);
    bus_write(8'h20, 8'h01);
    bus_write(8'h21, 8'd5);
    exp_q.push_back(8'd199);
    exp_q.push_back(8'd198);
    for (int i = 0; i < 2; i++) begin
      bus_read(8'h22, got);
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL midrun_count i=%0d got=%0d exp=%0d", i, got, exp); end
    end
    bus_write(8'h20, 8'h01);
    exp_q.push_back(8'd5);
    bus_read(8'h22, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL restart_count got=%0d exp=%0d", got, exp); end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (o_tick !== (k == 6)) begin errors++; $display("FAIL restart_tick k=%0d got=%b exp=%b", k, o_tick, k == 6); end
    end
  endtask

  task automatic test_reset_midcount;
    bus_write(8'h21, 8'h40);
    bus_write(8'h24, 8'h10);
    bus_write(8'h20, 8'h05);
    exp_q.push_back(8'h40);
    bus_read(8'h22, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp)    begin errors++; $display("FAIL pre_rst_count got=%h exp=%h", got, exp); end
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got=%b exp=1", o_irq); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dout !== 8'h00)  begin errors++; $display("FAIL async_rst_dout got=%h exp=00", dout); end
    checks++; if (o_irq !== 1'b0)  begin errors++; $display("FAIL async_rst_irq got=%b exp=0", o_irq); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL async_rst_tick got=%b exp=0", o_tick); end
    @(negedge clk);
    rst = 1'b1;
    drive(8'h22, 8'h00, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back(8'h00);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (dout !== exp) begin errors++; $display("FAIL post_rst_count k=%0d got=%h exp=%h", k, dout, exp); end
    end
    exp_q.push_back(8'h00);
    bus_read(8'h20, got);
    exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL post_rst_ctrl got=%h exp=%h", got, exp); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    test_reset();
    test_oneshot();
    test_auto_irq();
    test_simultaneous();
    test_reload_midrun();
    test_reset_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_mmio.md
Name: timer_mmio

Overview:
- Programmable 8-bit down-counting timer peripheral on the CPU's MMIO page, instantiated inside the memory wrapper beside the XALU, LEDS and RAND peripherals.
- Shares their bus: addr, din, write_en, dout.
- The wrapper gates write_en with the chip select for addresses BASE_ADDR..BASE_ADDR+7 and muxes this block's dout into the CPU read path.
- Provides a prescaled tick, a sticky expiry flag and a level interrupt, so programs can busy-wait or poll for delays.

Parameters:
- BASE_ADDR, 8'h20, MMIO base address; the block decodes addr[7:3] == BASE_ADDR[7:3].
- data_width, 8, bus data width. Only 8 is supported.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- addr  input  8  bus address.
- din  input  8  write data.
- write_en  input  1  write strobe, already qualified by the wrapper's chip select.
- dout  output  8  registered read data.
- o_tick  output  1  one-cycle pulse on every expiry.
- o_irq  output  1  level interrupt, equal to FLAG & IRQ_EN.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL: R/W. bit0 EN, bit1 AUTO, bit2 IRQ_EN. Reads return bits 7:3 as 0; bit0 reads the live RUN state.
  - 1 RELOAD: R/W.
  - 2 COUNT: R/W. A write loads COUNT directly and clears the prescaler.
  - 3 STATUS: bit0 FLAG. Writing a 1 to bit0 clears FLAG.
  - 4 PRESCALE: R/W.
  - 5-7: read 0, writes ignored.
- Writes: take effect at the clock edge where write_en=1 and the addr decode matches. Writes with a non-matching addr are ignored.
- Read latency: dout <= selected register, registered every cycle, so latency is 1 cycle (same as the RAM read). A non-matching addr gives dout <= 0.
- States:
  - IDLE: count and prescaler hold.
  - RUN: counting.
  - DONE: one-shot finished; behaves like IDLE, and FLAG stays as set.
- CTRL write with EN=1 (from any state, including RUN): COUNT <= RELOAD, PCNT <= 0, go to RUN. This is a restart.
- CTRL write with EN=0: go to IDLE. COUNT and PCNT hold.
- In RUN, every cycle:
  - If PCNT == PRESCALE: PCNT <= 0 and a tick occurs. Otherwise PCNT <= PCNT+1.
  - On a tick with COUNT != 0: COUNT <= COUNT-1.
  - On a tick with COUNT == 0 (expiry): FLAG <= 1, o_tick = 1 for exactly one cycle.
    - AUTO=1: COUNT <= RELOAD, stay in RUN.
    - AUTO=0: go to DONE, EN reads 0.
- Period: (RELOAD+1)*(PRESCALE+1) cycles from the EN write to the first expiry, and the same between auto-reload expiries.
  - RELOAD=0 with PRESCALE=0 and AUTO=1 gives an o_tick every cycle.
- Arithmetic: all counters are 8-bit unsigned. COUNT is never decremented below 0. PCNT compares for equality only.
- Simultaneous events:
  - FLAG clear write in the same cycle as an expiry: the set wins, FLAG=1.
  - COUNT write in the same cycle as a tick: the write wins, no decrement, PCNT <= 0.
  - RELOAD write while in RUN: COUNT is unaffected; the new value is used at the next reload.
  - CTRL write in the same cycle as an expiry: the CTRL write wins (restart or stop); FLAG is still set and o_tick still pulses.
- Reset (asserted at any time, including mid-count): state IDLE. CTRL, RELOAD, COUNT, PRESCALE, PCNT, FLAG and dout all 0. o_tick=0, o_irq=0. Outputs go to these values immediately, without waiting for a clock edge.

Test Plan:
- Reset then read each offset 0-7: dout=0 one cycle after each addr. Write 8'hA5 to RELOAD and read it back: dout=8'hA5 one cycle later. Write to offset 6, then read offset 6: dout=0.
- RELOAD=3, PRESCALE=0, CTRL=8'h01 (one-shot): o_tick pulses exactly 4 cycles after the write, once only. Afterwards CTRL reads 8'h00, STATUS reads 8'h01 and COUNT reads 0.
- RELOAD=1, PRESCALE=2, CTRL=8'h07 (auto, IRQ): o_tick every 6 cycles over 5 periods. o_irq rises with the first tick. Write 8'h01 to STATUS: o_irq falls the next cycle, then re-asserts at the next tick.
- STATUS clear timed onto an expiry cycle: FLAG stays 1. COUNT write of 8'h10 on a tick cycle: COUNT reads 8'h10, not 8'h0F.
- RELOAD=200, CTRL=8'h01, then RELOAD=5 written mid-run: COUNT keeps decrementing from 200. Rewriting CTRL=8'h01 restarts from 5.
- rst pulled low mid-count (COUNT=8'h40) between clock edges: all outputs are 0 immediately. After release the timer is IDLE, and COUNT holds 0 over 20 cycles.
